// File: rtl/rv_arb_pkg.sv
// Shared types and helpers for the round-robin ready/valid arbiter.
// The burst FSM states are used only when RV_ARB_BURST_EN is defined.
package rv_arb_pkg;

   typedef enum logic [0:0] {
      ARB_FREE,
      ARB_LOCKED
   } arb_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// Combinational round-robin pick: first valid requester after ptr, wrapping.
// Bits above ptr are searched first, then the unmasked copy covers the wrap.
module rv_rr_pick
   import rv_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any_valid,
   output logic [IDX_W-1:0]   sel
);

   localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);

   logic [NUM_REQ-1:0]   mask;
   logic [2*NUM_REQ-1:0] dbl;
   logic [IDX_W:0]       pos;

   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask[i] = (i > int'(ptr));
      end
   end

   assign dbl = {valid, valid & mask};

   // Scan high to low so the lowest set bit wins.
   always_comb begin
      pos = '0;
      for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
         if (dbl[i]) begin
            pos = (IDX_W + 1)'(i);
         end
      end
   end

   assign any_valid = |valid;
   assign sel       = IDX_W'((pos >= NumReqW) ? (pos - NumReqW) : pos);

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin merge of NUM_REQ ready/valid streams into one registered output stage.
// Define RV_ARB_BURST_EN to let a granted requester keep the grant for up to BURST_LEN beats.
module rv_rr_arbiter
   import rv_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4,
   localparam int unsigned IDX_W     = idx_w(NUM_REQ)
) (
   input  logic                          clock_port,
   input  logic                          reset_port,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] input_port_data,
   input  logic [NUM_REQ-1:0]            input_port_valid,
   output logic [NUM_REQ-1:0]            input_port_ready,
   output logic [DATA_WIDTH-1:0]         output_port_data,
   output logic [IDX_W-1:0]              output_port_src,
   output logic                          output_port_valid,
   input  logic                          output_port_ready
);

   if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1 || BURST_LEN > 256) begin : g_param_check
      $error("rv_rr_arbiter: parameter out of range");
   end

   logic                  stage_ready;
   logic                  any_valid;
   logic                  transfer;
   logic [IDX_W-1:0]      pick_sel;
   logic [IDX_W-1:0]      sel;
   logic [IDX_W-1:0]      ptr_q;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] data_q;
   logic [IDX_W-1:0]      src_q;
   logic                  valid_q;

   rv_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .valid     (input_port_valid),
      .ptr       (ptr_q),
      .any_valid (any_valid),
      .sel       (pick_sel)
   );

   assign stage_ready = ~valid_q | output_port_ready;

`ifdef RV_ARB_BURST_EN
   localparam logic [8:0] BurstLenW = 9'(BURST_LEN);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] lock_q, lock_d;
   logic [8:0]       cnt_q, cnt_d;
   logic             lock_hold;

   // The lock only overrides the pick while its owner keeps valid high.
   assign lock_hold = (state_q == ARB_LOCKED) && input_port_valid[lock_q];
   assign sel       = lock_hold ? lock_q : pick_sel;

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      if (state_q == ARB_LOCKED && !lock_hold) begin
         state_d = ARB_FREE;
         cnt_d   = '0;
      end
      if (transfer) begin
         if (lock_hold) begin
            if (cnt_q + 9'd1 >= BurstLenW) begin
               state_d = ARB_FREE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end else if (BurstLenW > 9'd1) begin
            state_d = ARB_LOCKED;
            lock_d  = sel;
            cnt_d   = 9'd1;
         end
      end
   end

   always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
         state_q <= ARB_FREE;
         lock_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign sel = pick_sel;
`endif

   always_comb begin
      input_port_ready = '0;
      sel_data         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         input_port_ready[i] = any_valid & stage_ready & (sel == IDX_W'(i));
         if (sel == IDX_W'(i)) begin
            sel_data = input_port_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign transfer = input_port_valid[sel] & input_port_ready[sel];

   always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= IDX_W'(NUM_REQ - 1);
      end else if (transfer) begin
         valid_q <= 1'b1;
         data_q  <= sel_data;
         src_q   <= sel;
         ptr_q   <= sel;
      end else if (output_port_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign output_port_valid = valid_q;
   assign output_port_data  = data_q;
   assign output_port_src   = src_q;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Self-checking bench for rv_rr_arbiter against a queue-free round-robin reference model.
// Build with RV_ARB_BURST_EN defined to also exercise the burst-lock scenarios.
module tb_rv_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BL = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_src;
   logic            out_valid;
   logic            out_ready;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the output register should hold and who was served last.
   logic          m_ov;
   logic [DW-1:0] m_od;
   int            m_os;
   int            m_ptr;
   int            last_grant;
`ifdef RV_ARB_BURST_EN
   bit            m_locked;
   int            m_lock;
   int            m_cnt;
`endif

   always #5 clk = ~clk;

   rv_rr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clock_port        (clk),
      .reset_port        (rst_n),
      .input_port_data   (in_data),
      .input_port_valid  (in_valid),
      .input_port_ready  (in_ready),
      .output_port_data  (out_data),
      .output_port_src   (out_src),
      .output_port_valid (out_valid),
      .output_port_ready (out_ready)
   );

   task automatic model_reset();
      m_ov       = 1'b0;
      m_od       = '0;
      m_os       = 0;
      m_ptr      = N - 1;
      last_grant = -1;
`ifdef RV_ARB_BURST_EN
      m_locked = 1'b0;
      m_lock   = 0;
      m_cnt    = 0;
`endif
   endtask

   function automatic int model_pick();
`ifdef RV_ARB_BURST_EN
      if (m_locked && in_valid[m_lock]) return m_lock;
`endif
      for (int j = 1; j <= N; j++) begin
         if (in_valid[(m_ptr + j) % N]) return (m_ptr + j) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      int s;
      r = '0;
      s = model_pick();
      if (s >= 0 && (!m_ov || out_ready)) r[s] = 1'b1;
      return r;
   endfunction

   // Advance the model by one clock using the inputs currently applied, then step the DUT.
   task automatic advance();
      int s;
      bit xfer;
      s    = model_pick();
      xfer = (s >= 0) && (!m_ov || out_ready);
      last_grant = xfer ? s : -1;
`ifdef RV_ARB_BURST_EN
      if (xfer && m_locked && s == m_lock) begin
         m_cnt++;
         if (m_cnt >= BL) m_locked = 1'b0;
      end else if (xfer) begin
         m_locked = (BL > 1);
         m_lock   = s;
         m_cnt    = 1;
      end else if (m_locked && !in_valid[m_lock]) begin
         m_locked = 1'b0;
      end
`endif
      if (xfer) begin
         m_ov  = 1'b1;
         m_od  = in_data[s*DW +: DW];
         m_os  = s;
         m_ptr = s;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, out_src, out_data} !== 11'd0) begin
            failures++;
            $display("FAIL reset_out cyc=%0d got v=%b src=%0d data=%h want 0/0/00", c, out_valid,
                     out_src, out_data);
         end
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready cyc=%0d got %b want 0000", c, in_ready);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_round_robin();
      in_valid  = 4'hF;
      in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== model_ready()) begin
            failures++;
            $display("FAIL rr_ready cyc=%0d got %b want %b", c, in_ready, model_ready());
         end
         checks++;
         if ({out_valid, out_src, out_data} !== {m_ov, 2'(m_os), m_od}) begin
            failures++;
            $display("FAIL rr_out cyc=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h", c,
                     out_valid, out_src, out_data, m_ov, m_os, m_od);
         end
`ifndef RV_ARB_BURST_EN
         if (c > 0) begin
            checks++;
            if (out_src !== 2'((c - 1) % 4) || out_data !== 8'(8'h10 + (c - 1) % 4)) begin
               failures++;
               $display("FAIL rr_seq cyc=%0d got src=%0d data=%h want src=%0d data=%h", c, out_src,
                        out_data, (c - 1) % 4, 8'h10 + (c - 1) % 4);
            end
         end
`endif
         advance();
      end
   endtask

   task automatic test_single();
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready cyc=%0d got %b want 0100", c, in_ready);
         end
         if (c > 0) begin
            checks++;
            if ({out_valid, out_src, out_data} !== {1'b1, 2'd2, 8'h12}) begin
               failures++;
               $display("FAIL single_out cyc=%0d got v=%b src=%0d data=%h want v=1 src=2 data=12",
                        c, out_valid, out_src, out_data);
            end
         end
         advance();
      end
   endtask

   task automatic test_stall();
      logic [10:0] held;
      in_valid  = 4'b0011;
      in_data   = {8'h13, 8'h12, 8'hB1, 8'hA0};
      out_ready = 1'b0;
      advance();
      held = {m_ov, 2'(m_os), m_od};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL stall_ready cyc=%0d got %b want 0000", c, in_ready);
         end
         checks++;
         if ({out_valid, out_src, out_data} !== held || !held[10]) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got %h want %h", c,
                     {out_valid, out_src, out_data}, held);
         end
         advance();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== model_ready() || in_ready === 4'b0000) begin
         failures++;
         $display("FAIL stall_release got %b want %b", in_ready, model_ready());
      end
      advance();
   endtask

`ifdef RV_ARB_BURST_EN
   task automatic test_burst();
      int exp_seq[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
      do_reset();
      in_valid  = 4'b0011;
      in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 4'(1 << exp_seq[c]) || in_ready !== model_ready()) begin
            failures++;
            $display("FAIL burst_grant cyc=%0d got %b want %b", c, in_ready, 4'(1 << exp_seq[c]));
         end
         advance();
      end
      do_reset();
      in_valid = 4'b0011;
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL burst_first got %b want 0001", in_ready);
      end
      advance();
      in_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0010 || in_ready !== model_ready()) begin
         failures++;
         $display("FAIL burst_drop got %b want 0010", in_ready);
      end
      advance();
      @(negedge clk);
      checks++;
      if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 8'h11}) begin
         failures++;
         $display("FAIL burst_drop_out got v=%b src=%0d data=%h want v=1 src=1 data=11",
                  out_valid, out_src, out_data);
      end
      advance();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks++;
         if (in_ready !== model_ready()) begin
            failures++;
            $display("FAIL rand_ready cyc=%0d valid=%b got %b want %b", c, in_valid, in_ready,
                     model_ready());
         end
         checks++;
         if ({out_valid, out_src, out_data} !== {m_ov, 2'(m_os), m_od}) begin
            failures++;
            $display("FAIL rand_out cyc=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                     c, out_valid, out_src, out_data, m_ov, m_os, m_od);
         end
         advance();
         // Producers may only change valid/data once idle or just accepted.
         for (int i = 0; i < N; i++) begin
            if (last_grant == i || !in_valid[i]) begin
               in_valid[i]         = 1'($urandom_range(0, 1));
               in_data[i*DW +: DW] = 8'($urandom);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      in_valid  = 4'hF;
      in_data   = {8'h43, 8'h42, 8'h41, 8'h40};
      out_ready = 1'b1;
      repeat (3) advance();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_src, out_data} !== 11'd0) begin
         failures++;
         $display("FAIL async_reset got v=%b src=%0d data=%h want 0/0/00", out_valid, out_src,
                  out_data);
      end
      model_reset();
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 4'b1010;
      #1;
      checks++;
      if (in_ready !== 4'b0010 || in_ready !== model_ready()) begin
         failures++;
         $display("FAIL post_reset_grant got %b want 0010", in_ready);
      end
      advance();
      @(negedge clk);
      checks++;
      if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 8'h41}) begin
         failures++;
         $display("FAIL post_reset_out got v=%b src=%0d data=%h want v=1 src=1 data=41",
                  out_valid, out_src, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_stall();
`ifdef RV_ARB_BURST_EN
      test_burst();
`endif
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
